// File: rtl/kei_i2c_intr_agg.sv
// kei_i2c_intr_agg: synchronises raw I2C interrupt sources into apb_clk,
// latches them per channel (edge or level), masks them and coalesces
// events by count or timeout into a single registered irq.
module kei_i2c_intr_agg #(
    parameter int NUM_INTR    = 15,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                apb_clk,
    input  logic                apb_rst,
    input  logic [NUM_INTR-1:0] intr_src,
    input  logic [NUM_INTR-1:0] edge_mode,
    input  logic [NUM_INTR-1:0] mask,
    input  logic                clr_we,
    input  logic [NUM_INTR-1:0] clr_data,
    input  logic [CNT_W-1:0]    coal_thresh,
    input  logic [CNT_W-1:0]    coal_timeout,
    output logic [NUM_INTR-1:0] raw_stat,
    output logic [NUM_INTR-1:0] masked_stat,
    output logic                irq,
    output logic [CNT_W-1:0]    ev_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_FIRE  = 2'd2;

    logic [SYNC_STAGES-1:0][NUM_INTR-1:0] r_sync;
    logic [NUM_INTR-1:0]                  r_prev;
    logic [NUM_INTR-1:0]                  r_raw;
    logic [1:0]                           r_state;
    logic [CNT_W-1:0]                     r_cnt;
    logic [CNT_W-1:0]                     r_tmr;
    logic                                 r_irq;

    logic [NUM_INTR-1:0] w_sync;
    logic [NUM_INTR-1:0] w_rise;
    logic [NUM_INTR-1:0] w_clr;
    logic [NUM_INTR-1:0] w_raw_nxt;
    logic                w_ev_any;
    logic                w_pend;
    logic [CNT_W-1:0]    w_thresh;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    w_tmr_nxt;
    logic                w_fire;
    logic [1:0]          w_state_d;
    logic [CNT_W-1:0]    w_cnt_d;
    logic [CNT_W-1:0]    w_tmr_d;

    // Multi-flop synchroniser chain plus one-cycle delayed copy for edge detect
    always_ff @(posedge apb_clk or posedge apb_rst) begin
        if (apb_rst) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= intr_src;
            for (int s = 1; s < SYNC_STAGES; s++)
                r_sync[s] <= r_sync[s-1];
            r_prev <= w_sync;
        end
    end

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_rise   = w_sync & ~r_prev;
    assign w_clr    = {NUM_INTR{clr_we}} & clr_data;
    // Edge channels: set beats clear. Level channels just track the synced line.
    assign w_raw_nxt = (edge_mode & (w_rise | (r_raw & ~w_clr))) | (~edge_mode & w_sync);

    // Both modes raise an event only on a synced rising edge of an enabled channel
    assign w_ev_any = |(w_rise & mask);
    assign w_pend   = |masked_stat;

    assign w_thresh  = (coal_thresh == '0) ? CNT_W'(1) : coal_thresh;
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_cnt_nxt = w_ev_any ? w_cnt_inc : r_cnt;
    assign w_tmr_nxt = (r_tmr == '1) ? r_tmr : r_tmr + CNT_W'(1);
    assign w_fire    = (w_cnt_nxt >= w_thresh) ||
                       ((coal_timeout != '0) && (w_tmr_nxt >= coal_timeout));

    // Per-channel status latch
    always_ff @(posedge apb_clk or posedge apb_rst) begin
        if (apb_rst) r_raw <= '0;
        else         r_raw <= w_raw_nxt;
    end

    // Coalescing FSM next-state, counter and timer
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_tmr_d   = r_tmr;
        case (r_state)
            S_IDLE: begin
                w_cnt_d = '0;
                w_tmr_d = '0;
                if (w_ev_any || w_pend) begin
                    w_cnt_d   = CNT_W'(1);
                    w_state_d = (w_thresh == CNT_W'(1)) ? S_FIRE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                w_cnt_d = w_cnt_nxt;
                w_tmr_d = w_tmr_nxt;
                // Everything cleared or masked takes precedence over a fire
                if (!w_pend) begin
                    w_state_d = S_IDLE;
                    w_cnt_d   = '0;
                    w_tmr_d   = '0;
                end else if (w_fire) begin
                    w_state_d = S_FIRE;
                end
            end
            S_FIRE: begin
                // Count is frozen at its fire value until the line drains
                if (!w_pend) begin
                    w_state_d = S_IDLE;
                    w_cnt_d   = '0;
                    w_tmr_d   = '0;
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_cnt_d   = '0;
                w_tmr_d   = '0;
            end
        endcase
    end

    // FSM state, counter, timer and registered irq
    always_ff @(posedge apb_clk or posedge apb_rst) begin
        if (apb_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_tmr   <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_tmr   <= w_tmr_d;
            r_irq   <= (w_state_d == S_FIRE);
        end
    end

    assign raw_stat    = r_raw;
    assign masked_stat = r_raw & mask;
    assign irq         = r_irq;
    assign ev_cnt      = r_cnt;

endmodule

// File: tb/tb_kei_i2c_intr_agg.sv
// Directed self-checking bench for kei_i2c_intr_agg (default parameters).
// Inputs change and outputs are sampled on the falling edge of apb_clk.
module tb_kei_i2c_intr_agg;

    localparam int N = 15;
    localparam int W = 8;

    logic         apb_clk;
    logic         apb_rst;
    logic [N-1:0] intr_src;
    logic [N-1:0] edge_mode;
    logic [N-1:0] mask;
    logic         clr_we;
    logic [N-1:0] clr_data;
    logic [W-1:0] coal_thresh;
    logic [W-1:0] coal_timeout;
    logic [N-1:0] raw_stat;
    logic [N-1:0] masked_stat;
    logic         irq;
    logic [W-1:0] ev_cnt;

    int n_cmp = 0;
    int n_err = 0;

    kei_i2c_intr_agg #(.NUM_INTR(N), .SYNC_STAGES(2), .CNT_W(W)) dut (
        .apb_clk     (apb_clk),
        .apb_rst     (apb_rst),
        .intr_src    (intr_src),
        .edge_mode   (edge_mode),
        .mask        (mask),
        .clr_we      (clr_we),
        .clr_data    (clr_data),
        .coal_thresh (coal_thresh),
        .coal_timeout(coal_timeout),
        .raw_stat    (raw_stat),
        .masked_stat (masked_stat),
        .irq         (irq),
        .ev_cnt      (ev_cnt)
    );

    initial apb_clk = 1'b0;
    always #5 apb_clk = ~apb_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge apb_clk);
    endtask

    // One-cycle source pulse; returns one falling edge later
    task automatic pulse(input int ch);
        intr_src[ch] = 1'b1;
        tick(1);
        intr_src[ch] = 1'b0;
    endtask

    task automatic clr(input logic [N-1:0] v);
        clr_we   = 1'b1;
        clr_data = v;
        tick(1);
        clr_we   = 1'b0;
        clr_data = '0;
    endtask

    initial begin
        apb_rst      = 1'b1;
        intr_src     = '0;
        edge_mode    = '1;
        mask         = '1;
        clr_we       = 1'b0;
        clr_data     = '0;
        coal_thresh  = 8'd1;
        coal_timeout = 8'd0;
        #12;
        chk("rst_raw", 32'(raw_stat), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_cnt", 32'(ev_cnt), 32'h0);
        tick(1);
        apb_rst = 1'b0;
        tick(1);

        // Edge latch, thresh=1: visible 3 edges after the source
        pulse(3);
        tick(1);
        chk("lat_early_raw", 32'(raw_stat), 32'h0);
        chk("lat_early_irq", 32'(irq), 32'h0);
        tick(1);
        chk("lat_raw", 32'(raw_stat), 32'h0008);
        chk("lat_irq", 32'(irq), 32'h1);
        clr(15'h0008);
        chk("clr_raw", 32'(raw_stat), 32'h0);
        tick(1);
        chk("clr_irq", 32'(irq), 32'h0);
        chk("clr_cnt", 32'(ev_cnt), 32'h0);

        // Count coalescing, thresh=4
        coal_thresh = 8'd4;
        for (int k = 0; k < 3; k++) begin
            pulse(1);
            tick(4);
        end
        chk("coal3_irq", 32'(irq), 32'h0);
        chk("coal3_cnt", 32'(ev_cnt), 32'h3);
        pulse(1);
        tick(1);
        chk("coal4_pre_irq", 32'(irq), 32'h0);
        tick(1);
        chk("coal4_irq", 32'(irq), 32'h1);
        chk("coal4_cnt", 32'(ev_cnt), 32'h4);
        tick(3);
        chk("coal_hold_cnt", 32'(ev_cnt), 32'h4);
        clr(15'h0002);
        tick(1);
        chk("coal_done_irq", 32'(irq), 32'h0);
        chk("coal_done_cnt", 32'(ev_cnt), 32'h0);

        // Timeout fire, thresh=10 timeout=5
        coal_thresh  = 8'd10;
        coal_timeout = 8'd5;
        pulse(6);
        tick(2);
        chk("to_accum_cnt", 32'(ev_cnt), 32'h1);
        tick(4);
        chk("to_pre_irq", 32'(irq), 32'h0);
        tick(1);
        chk("to_irq", 32'(irq), 32'h1);
        chk("to_cnt", 32'(ev_cnt), 32'h1);
        clr(15'h0040);
        tick(1);
        chk("to_done_irq", 32'(irq), 32'h0);
        // Clear before the timeout expires: no irq ever
        pulse(6);
        tick(2);
        tick(2);
        clr(15'h0040);
        tick(1);
        chk("to_abort_cnt", 32'(ev_cnt), 32'h0);
        tick(4);
        chk("to_abort_irq", 32'(irq), 32'h0);

        // Level mode on channel 0
        coal_thresh  = 8'd1;
        coal_timeout = 8'd0;
        edge_mode[0] = 1'b0;
        intr_src[0]  = 1'b1;
        tick(3);
        chk("lvl_raw", 32'(raw_stat), 32'h0001);
        chk("lvl_irq", 32'(irq), 32'h1);
        clr(15'h0001);
        chk("lvl_clr_ign", 32'(raw_stat), 32'h0001);
        tick(3);
        chk("lvl_hold_irq", 32'(irq), 32'h1);
        intr_src[0] = 1'b0;
        tick(2);
        chk("lvl_fall_early", 32'(raw_stat), 32'h0001);
        tick(1);
        chk("lvl_fall_raw", 32'(raw_stat), 32'h0);
        tick(1);
        chk("lvl_fall_irq", 32'(irq), 32'h0);
        edge_mode[0] = 1'b1;

        // Masked channel 5, then unmask
        mask = ~15'h0020;
        pulse(5);
        tick(4);
        chk("mask_raw", 32'(raw_stat), 32'h0020);
        chk("mask_mstat", 32'(masked_stat), 32'h0);
        chk("mask_irq", 32'(irq), 32'h0);
        mask = '1;
        tick(1);
        chk("unmask_irq", 32'(irq), 32'h1);
        clr(15'h0020);
        tick(1);
        chk("unmask_done", 32'(irq), 32'h0);

        // Set and clear of bit 2 on the same edge: set wins
        pulse(2);
        tick(1);
        clr(15'h0004);
        chk("setclr_raw", 32'(raw_stat), 32'h0004);
        chk("setclr_irq", 32'(irq), 32'h1);
        clr(15'h0004);
        chk("setclr_after", 32'(raw_stat), 32'h0);

        // Async reset in FIRE with ev_cnt=7
        tick(2);
        coal_thresh = 8'd7;
        for (int k = 0; k < 7; k++) begin
            pulse(9);
            tick(4);
        end
        chk("pre_rst_irq", 32'(irq), 32'h1);
        chk("pre_rst_cnt", 32'(ev_cnt), 32'h7);
        #1;
        apb_rst = 1'b1;
        #1;
        chk("arst_irq", 32'(irq), 32'h0);
        chk("arst_raw", 32'(raw_stat), 32'h0);
        chk("arst_cnt", 32'(ev_cnt), 32'h0);
        tick(1);
        apb_rst = 1'b0;
        tick(2);
        chk("post_rst_irq", 32'(irq), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/kei_i2c_intr_agg.md
Name: kei_i2c_intr_agg

Overview:
- Parametrised interrupt aggregator between the I2C core's raw interrupt lines and the APB-side interrupt output.
- Synchronises NUM_INTR sources from the i2c_clk domain into apb_clk and latches them per channel in edge or level mode.
- Applies a per-channel mask and write-1-to-clear, then coalesces events by count or timeout before raising a single irq.
- Successor to the fixed-width intr bundle: generalises channel count and adds mode, masking and coalescing.

Parameters:
- NUM_INTR, 15, number of interrupt channels (≥1).
- SYNC_STAGES, 2, synchroniser flops per source bit (≥2).
- CNT_W, 8, width of the coalescing event counter, timer and thresholds.

Ports:
- apb_clk  input  1  sole clock.
- apb_rst  input  1  asynchronous reset, active-high.
- intr_src  input  NUM_INTR  raw interrupt sources, asynchronous to apb_clk.
- edge_mode  input  NUM_INTR  per channel: 1 = rising-edge latched, 0 = level.
- mask  input  NUM_INTR  per channel: 1 = enabled.
- clr_we  input  1  clear strobe, one cycle.
- clr_data  input  NUM_INTR  write-1-to-clear vector, valid with clr_we.
- coal_thresh  input  CNT_W  event count that fires irq; 0 is treated as 1.
- coal_timeout  input  CNT_W  cycles in ACCUM before forced fire; 0 disables the timeout.
- raw_stat  output  NUM_INTR  latched status before masking.
- masked_stat  output  NUM_INTR  raw_stat & mask (combinational from registers).
- irq  output  1  aggregated interrupt, registered.
- ev_cnt  output  CNT_W  current coalescing count.

Behaviour:
- Reset (async, active-high): sync chains, prev, raw_stat, ev_cnt, timer and irq all go to 0; state goes to IDLE.
- Sync: per-bit SYNC_STAGES flop chain gives sync. prev is sync delayed one cycle. rise = sync & ~prev.
- Edge channel: raw_stat[i] sets on rise[i]. It clears on clr_we & clr_data[i]. Set and clear in the same cycle: set wins.
- Level channel: raw_stat[i] <= sync[i] every cycle. Clear is ignored.
- Mode change on a channel takes effect the next cycle. Edge-to-level drops any latched bit unless sync = 1.
- Event: ev_any = |(rise & mask), with rise qualified by mode. Level channels generate an event only on sync rising.
- Latency: intr_src edge to raw_stat = SYNC_STAGES+1 cycles. raw_stat to irq (thresh ≤ 1) = same edge, so irq is high SYNC_STAGES+1 cycles after the source.
- FSM state IDLE: irq=0, ev_cnt=0, timer=0.
  - On ev_any, or masked_stat ≠ 0 (e.g. a pending bit unmasked), with effective thresh = 1: go to FIRE.
  - Otherwise on that condition: go to ACCUM with ev_cnt=1, timer=0.
- FSM state ACCUM:
  - Each cycle timer += 1; each ev_any cycle ev_cnt += 1. Both saturate at all-ones; multiple simultaneous channel events count as 1.
  - Go to FIRE when the next ev_cnt ≥ thresh, or when coal_timeout ≠ 0 and the next timer ≥ coal_timeout.
  - If masked_stat == 0 (all cleared or masked) with no fire condition: go to IDLE.
  - If fire and all-cleared occur in the same cycle: IDLE wins.
- FSM state FIRE: irq=1 from the edge that enters FIRE. Stays while masked_stat ≠ 0. Once masked_stat == 0: go to IDLE, irq=0 on the same edge, ev_cnt=0.
- New events in FIRE do not change ev_cnt; ev_cnt holds its value at fire.
- Level channels keep irq asserted until the source deasserts or the channel is masked.
- Threshold or timeout changes apply on the next comparison cycle, with no restart.
- Reset mid-operation: immediate return to reset values; latched events are lost.

Test Plan:
- Edge latch, SYNC_STAGES=2, thresh=1, mask=all: intr_src[3] pulse 1 cycle → raw_stat[3]=1 and irq=1 3 cycles later. clr_we with clr_data=0x0008 → raw_stat=0 and irq=0 the next cycle.
- Coalescing, thresh=4, timeout=0: 3 separate edge events → irq=0 with ev_cnt=3. 4th event → irq=1 on that edge, ev_cnt=4.
- Timeout, thresh=10, timeout=5: single event → irq rises 5 cycles after entering ACCUM. Clearing all bits before then → IDLE, irq never asserted.
- Level mode on channel 0: hold intr_src[0]=1 → irq stays 1 despite clr_we on bit 0. Deassert → raw_stat[0]=0 after 3 cycles and irq drops.
- Mask and priority: event on masked channel 5 → raw_stat[5]=1, irq=0. Unmask → irq=1 next cycle (thresh=1). Set and clear of bit 2 in the same cycle → raw_stat[2]=1.
- Async reset asserted in FIRE with ev_cnt=7 → irq=0, raw_stat=0, ev_cnt=0 immediately, without waiting for a clock edge.
